// File: rtl/fixed_to_dac_pkg.sv
// fixed_to_dac_pkg: default formats, flag and stage payload types for the fixed-point to DAC converter.
package fixed_to_dac_pkg;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CH_W = 2;
    localparam int DEF_IN_W = 24;
    localparam int DEF_IN_FRAC = 16;
    localparam int DEF_GAIN_W = 16;
    localparam int DEF_GAIN_FRAC = 8;
    localparam int DEF_DAC_W = 8;

    typedef struct packed {
        logic sat;
        logic clip_hi;
        logic clip_lo;
    } flags_t;

    typedef struct packed {
        logic valid;
        logic [DEF_CH_W-1:0] ch;
        logic [DEF_IN_W-1:0] data;
        logic [DEF_GAIN_W-1:0] gain;
        flags_t flags;
    } stage_t;

    function automatic int ch_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dac_coef_bank.sv
// dac_coef_bank: per-channel offset/gain registers with one write port and combinational reads.
module dac_coef_bank import fixed_to_dac_pkg::*; #(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W = DEF_CH_W,
    parameter int IN_W = DEF_IN_W,
    parameter int GAIN_W = DEF_GAIN_W,
    parameter logic [IN_W-1:0] OFFSET_DEFAULT = 24'h020000,
    parameter logic [GAIN_W-1:0] GAIN_DEFAULT = 16'h3300
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [IN_W-1:0]   cfg_data,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [IN_W-1:0]   offset,
    output logic [GAIN_W-1:0] gain
);
    logic [IN_W-1:0] offset_r [NUM_CH];
    logic [GAIN_W-1:0] gain_r [NUM_CH];
    logic [CH_W-1:0] rd_idx;

    // Out-of-range tags read channel 0; out-of-range writes are dropped.
    assign rd_idx = int'(rd_ch) < NUM_CH ? rd_ch : '0;
    assign offset = offset_r[rd_idx];
    assign gain = gain_r[rd_idx];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                offset_r[i] <= OFFSET_DEFAULT;
                gain_r[i] <= GAIN_DEFAULT;
            end
        end else if (cfg_we && int'(cfg_ch) < NUM_CH) begin
            if (cfg_sel)
                gain_r[cfg_ch] <= cfg_data[GAIN_W-1:0];
            else
                offset_r[cfg_ch] <= cfg_data;
        end
endmodule

// File: rtl/fixed_to_dac_mc.sv
// fixed_to_dac_mc: multi-channel offset/clamp/gain/round pipeline producing saturated DAC codes.
module fixed_to_dac_mc import fixed_to_dac_pkg::*; #(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IN_W = DEF_IN_W,
    parameter int IN_FRAC = DEF_IN_FRAC,
    parameter int GAIN_W = DEF_GAIN_W,
    parameter int GAIN_FRAC = DEF_GAIN_FRAC,
    parameter int DAC_W = DEF_DAC_W,
    parameter logic [IN_W-1:0] VREF = 24'h050000,
    parameter logic [IN_W-1:0] OFFSET_DEFAULT = 24'h020000,
    parameter logic [GAIN_W-1:0] GAIN_DEFAULT = 16'h3300,
    localparam int CH_W = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DAC_W-1:0]  out_code,
    output logic [2:0]        out_flags,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [IN_W-1:0]   cfg_data,
    output logic [NUM_CH-1:0] clip_sticky,
    input  logic              clip_clr
);
    localparam int F = IN_FRAC + GAIN_FRAC;
    localparam int P_W = IN_W + GAIN_W;
    localparam logic [P_W:0] RND = (P_W + 1)'(1) << (F - 1);

    typedef struct packed {
        logic valid;
        logic [CH_W-1:0] ch;
        logic [IN_W-1:0] data;
        logic [GAIN_W-1:0] gain;
        flags_t flags;
    } pipe_t;

    typedef struct packed {
        logic valid;
        logic [CH_W-1:0] ch;
        logic [P_W-1:0] data;
        flags_t flags;
    } prod_t;

    logic advance;
    logic [IN_W-1:0] offset;
    logic [GAIN_W-1:0] gain;
    logic signed [IN_W:0] sum;
    logic clip_lo, clip_hi, sat;
    logic [P_W:0] rounded;
    logic [2:0] s3_flags;
    logic [CH_W-1:0] sticky_idx;
    pipe_t s1, s1_next;
    prod_t s2, s2_next;

    dac_coef_bank #(
        .NUM_CH(NUM_CH),
        .CH_W(CH_W),
        .IN_W(IN_W),
        .GAIN_W(GAIN_W),
        .OFFSET_DEFAULT(OFFSET_DEFAULT),
        .GAIN_DEFAULT(GAIN_DEFAULT)
    ) u_coef (
        .clk(clk),
        .reset(reset),
        .cfg_we(cfg_we),
        .cfg_sel(cfg_sel),
        .cfg_ch(cfg_ch),
        .cfg_data(cfg_data),
        .rd_ch(in_ch),
        .offset(offset),
        .gain(gain)
    );

    assign advance = clk_en && (!out_valid || out_ready);
    assign in_ready = advance;

    assign sum = $signed({in_data[IN_W-1], in_data}) + $signed({offset[IN_W-1], offset});
    assign clip_lo = sum[IN_W];
    assign clip_hi = !sum[IN_W] && sum > $signed({1'b0, VREF});

    always_comb begin
        s1_next.valid = in_valid;
        s1_next.ch = in_ch;
        s1_next.data = clip_lo ? '0 : clip_hi ? VREF : sum[IN_W-1:0];
        s1_next.gain = gain;
        s1_next.flags = '{sat: 1'b0, clip_hi: clip_hi, clip_lo: clip_lo};
    end

    always_comb begin
        s2_next.valid = s1.valid;
        s2_next.ch = s1.ch;
        s2_next.data = P_W'(s1.data) * P_W'(s1.gain);
        s2_next.flags = s1.flags;
    end

    // Half-up rounding; any bit above the DAC range means saturation.
    assign rounded = ({1'b0, s2.data} + RND) >> F;
    assign sat = |rounded[P_W:DAC_W];
    assign s3_flags = {s2.flags.sat | sat, s2.flags.clip_hi, s2.flags.clip_lo};
    assign sticky_idx = int'(s2.ch) < NUM_CH ? s2.ch : '0;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            out_valid <= 1'b0;
            out_ch <= '0;
            out_code <= '0;
            out_flags <= '0;
        end else if (advance) begin
            s1 <= s1_next;
            s2 <= s2_next;
            out_valid <= s2.valid;
            out_ch <= s2.ch;
            out_code <= sat ? '1 : rounded[DAC_W-1:0];
            out_flags <= s3_flags;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset)
            clip_sticky <= '0;
        else if (clip_clr)
            clip_sticky <= '0;
        else if (advance && s2.valid && |s3_flags)
            clip_sticky[sticky_idx] <= 1'b1;
endmodule
